uart_tx_parity: RTL and testbench

//  UART transmitter with parity generation; the line-side stage directly upstream of uart_rx.

---
 rtl/uart_tx_parity_if.sv | 14 +
 rtl/uart_tx_parity.sv | 136 +++++++++++++
 tb/tb_uart_tx_parity.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_parity_if.sv
// Handshake bundle between a frame source and uart_tx_parity.
// The master requests frames; the slave (the transmitter) drives the line and status.
interface uart_tx_parity_if #(
  parameter int DBIT = 8
);
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx;
  logic            tx_busy;
  logic            tx_done_tick;

  modport master (output tx_start, din, input tx, tx_busy, tx_done_tick);
  modport slave  (input tx_start, din, output tx, tx_busy, tx_done_tick);
endinterface

// File: rtl/uart_tx_parity.sv
// UART transmitter: start, DBIT data bits LSB-first, parity, stop, timed by a 16x s_tick.
// Even parity by default; define UART_TX_ODD_PARITY_EN for odd parity.
module uart_tx_parity #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  uart_tx_parity_if.slave bus
);

  // The tick counter must also reach SB_TICK-1 for 1.5 or 2 stop bits.
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_next;
  logic [SW-1:0]   s_cnt, s_cnt_next;
  logic [NW-1:0]   n_cnt, n_cnt_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            p_reg, p_next;
  logic            tx_reg, tx_next;
  logic            done;
  logic            din_par;

`ifdef UART_TX_ODD_PARITY_EN
  assign din_par = ~^bus.din;
`else
  assign din_par = ^bus.din;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      s_cnt  <= '0;
      n_cnt  <= '0;
      b_reg  <= '0;
      p_reg  <= 1'b0;
      tx_reg <= 1'b1;
    end else begin
      state  <= state_next;
      s_cnt  <= s_cnt_next;
      n_cnt  <= n_cnt_next;
      b_reg  <= b_next;
      p_reg  <= p_next;
      tx_reg <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    s_cnt_next = s_cnt;
    n_cnt_next = n_cnt;
    b_next     = b_reg;
    p_next     = p_reg;
    done       = 1'b0;
    tx_next    = 1'b1;

    case (state)
      IDLE: begin
        if (bus.tx_start) begin
          b_next     = bus.din;
          p_next     = din_par;
          s_cnt_next = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == BIT_LAST) begin
            s_cnt_next = '0;
            n_cnt_next = '0;
            state_next = DATA;
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == BIT_LAST) begin
            s_cnt_next = '0;
            b_next     = b_reg >> 1;
            if (n_cnt == N_LAST) begin
              state_next = PARITY;
            end else begin
              n_cnt_next = n_cnt + 1'b1;
            end
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_cnt == BIT_LAST) begin
            s_cnt_next = '0;
            state_next = STOP;
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == STOP_LAST) begin
            s_cnt_next = '0;
            done       = 1'b1;
            state_next = IDLE;
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // The line is registered, so its value is chosen from where the FSM is heading.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      PARITY:  tx_next = p_next;
      default: tx_next = 1'b1;
    endcase
  end

  assign bus.tx           = tx_reg;
  assign bus.tx_busy      = (state != IDLE);
  assign bus.tx_done_tick = done & ~reset;

endmodule

// File: tb/tb_uart_tx_parity.sv
// Self-checking bench for uart_tx_parity: a tick-counting line model plus a mid-bit
// sampling receiver model decide what the serial line must carry.
module tb_uart_tx_parity;

  localparam int DBIT        = 8;
  localparam int SB_TICK     = 16;
  localparam int FRAME_TICKS = 16 * (DBIT + 2) + SB_TICK;
  localparam int MAXC        = 2048;
`ifdef UART_TX_ODD_PARITY_EN
  localparam bit ODD = 1'b1;
`else
  localparam bit ODD = 1'b0;
`endif

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic s_tick = 1'b0;

  int tests = 0;
  int fails = 0;
  int tick_period = 1;
  int tick_phase  = 0;

  // Trace of one frame: line outputs and the number of ticks the frame has consumed.
  logic rec_tx    [0:MAXC-1];
  logic rec_busy  [0:MAXC-1];
  logic rec_done  [0:MAXC-1];
  logic rec_stick [0:MAXC-1];
  int   rec_ticks [0:MAXC-1];
  int   n_cyc;
  logic pre_tx, pre_busy, pre_done;

  uart_tx_parity_if #(.DBIT(DBIT)) bus ();

  uart_tx_parity #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk    (clk),
    .reset  (reset),
    .s_tick (s_tick),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive_tick();
    if (tick_period <= 0) begin
      s_tick = 1'b0;
    end else begin
      s_tick = (tick_phase == 0);
      tick_phase = (tick_phase + 1) % tick_period;
    end
  endtask

  // Line level expected after t ticks of a frame carrying w.
  function automatic logic model_bit(input logic [DBIT-1:0] w, input int t);
    int idx;
    idx = t / 16;
    if (idx == 0) return 1'b0;
    if (idx <= DBIT) return w[idx-1];
    if (idx == DBIT + 1) return ((($countones(w) % 2) == 1) ^ ODD);
    return 1'b1;
  endfunction

  // Receiver model: sample the line at the middle of bit b (0 = start bit).
  function automatic logic rx_bit(input int b);
    for (int k = 0; k < n_cyc; k++)
      if (rec_ticks[k] == 16 * b + 8) return rec_tx[k];
    return 1'bx;
  endfunction

  function automatic logic [DBIT-1:0] rx_word();
    logic [DBIT-1:0] w;
    for (int i = 0; i < DBIT; i++) w[i] = rx_bit(i + 1);
    return w;
  endfunction

  function automatic logic rx_parity_err();
    logic [DBIT:0] all;
    all = {rx_bit(DBIT + 1), rx_word()};
    return ((($countones(all) % 2) == 1) ^ ODD);
  endfunction

  // Requests one frame and records the line until the model says it has ended.
  task automatic run_frame(input logic [DBIT-1:0] data, input int inject_cycle,
                           input bit inject_at_done, input int reset_cycle,
                           input int freeze_cycle);
    int ticks;
    bit fin;
    ticks = 0;
    fin   = 1'b0;
    n_cyc = 0;
    @(negedge clk);
    bus.din = data;
    bus.tx_start = 1'b1;
    drive_tick();
    #1;
    pre_tx = bus.tx; pre_busy = bus.tx_busy; pre_done = bus.tx_done_tick;
    for (int k = 0; k < MAXC && !fin; k++) begin
      @(negedge clk);
      bus.tx_start = 1'b0;
      bus.din = DBIT'($urandom);
      if (freeze_cycle >= 0 && k >= freeze_cycle && k < freeze_cycle + 50) s_tick = 1'b0;
      else drive_tick();
      if (k == inject_cycle || (inject_at_done && s_tick && ticks == FRAME_TICKS - 1)) begin
        bus.tx_start = 1'b1;
        bus.din = '1;
      end
      if (k == reset_cycle) reset = 1'b1;
      #1;
      rec_tx[k] = bus.tx; rec_busy[k] = bus.tx_busy; rec_done[k] = bus.tx_done_tick;
      rec_stick[k] = s_tick; rec_ticks[k] = ticks;
      n_cyc = k + 1;
      if (k == reset_cycle) begin
        fin = 1'b1;
      end else begin
        if (s_tick && ticks == FRAME_TICKS - 1) fin = 1'b1;
        if (s_tick) ticks++;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_tick = ~s_tick;
      bus.tx_start = ~bus.tx_start;
      bus.din = DBIT'($urandom);
      #1;
      tests++;
      if ({bus.tx, bus.tx_busy, bus.tx_done_tick} !== 3'b100) begin
        fails++;
        $display("[TB] FAIL reset_hold cycle %0d: tx/busy/done=%b%b%b want 100", i,
                 bus.tx, bus.tx_busy, bus.tx_done_tick);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b0;
      bus.tx_start = 1'b0;
      s_tick = 1'b1;
      #1;
      tests++;
      if ({bus.tx, bus.tx_busy, bus.tx_done_tick} !== 3'b100) begin
        fails++;
        $display("[TB] FAIL reset_release cycle %0d: tx/busy/done=%b%b%b want 100", i,
                 bus.tx, bus.tx_busy, bus.tx_done_tick);
      end
    end
  endtask

  task automatic test_parity();
    logic [DBIT-1:0] words [2];
    logic            pars  [2];
    logic            etx, edone;
    words[0] = 8'h35; pars[0] = 1'b0 ^ ODD;
    words[1] = 8'h34; pars[1] = 1'b1 ^ ODD;
    tick_period = 1;
    for (int f = 0; f < 2; f++) begin
      run_frame(words[f], -1, 1'b0, -1, -1);
      tests++;
      if ({pre_tx, pre_busy, pre_done} !== 3'b100) begin
        fails++;
        $display("[TB] FAIL parity_idle: tx/busy/done=%b%b%b want 100", pre_tx, pre_busy, pre_done);
      end
      for (int k = 0; k < n_cyc; k++) begin
        etx = model_bit(words[f], rec_ticks[k]);
        edone = rec_stick[k] && (rec_ticks[k] == FRAME_TICKS - 1);
        tests++;
        if ({rec_tx[k], rec_busy[k], rec_done[k]} !== {etx, 1'b1, edone}) begin
          fails++;
          $display("[TB] FAIL parity_frame %h cycle %0d: tx/busy/done=%b%b%b want %b1%b",
                   words[f], k, rec_tx[k], rec_busy[k], rec_done[k], etx, edone);
        end
      end
      tests++;
      if (rx_bit(DBIT + 1) !== pars[f]) begin
        fails++;
        $display("[TB] FAIL parity_bit %h: got %b want %b", words[f], rx_bit(DBIT + 1), pars[f]);
      end
      tests++;
      if ({rec_done[FRAME_TICKS-2], rec_done[FRAME_TICKS-1]} !== 2'b01) begin
        fails++;
        $display("[TB] FAIL done_timing %h: done at cycles 174/175=%b%b want 01", words[f],
                 rec_done[FRAME_TICKS-2], rec_done[FRAME_TICKS-1]);
      end
    end
  endtask

  task automatic test_ignore();
    logic etx, edone;
    int   ndone;
    tick_period = 1;
    run_frame(8'hA5, 40, 1'b1, -1, -1);
    ndone = 0;
    for (int k = 0; k < n_cyc; k++) begin
      etx = model_bit(8'hA5, rec_ticks[k]);
      edone = rec_stick[k] && (rec_ticks[k] == FRAME_TICKS - 1);
      if (rec_done[k] === 1'b1) ndone++;
      tests++;
      if ({rec_tx[k], rec_busy[k], rec_done[k]} !== {etx, 1'b1, edone}) begin
        fails++;
        $display("[TB] FAIL ignore_frame cycle %0d: tx/busy/done=%b%b%b want %b1%b",
                 k, rec_tx[k], rec_busy[k], rec_done[k], etx, edone);
      end
    end
    tests++;
    if (ndone !== 1) begin
      fails++;
      $display("[TB] FAIL ignore_done_count: got %0d want 1", ndone);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.tx_start = 1'b0;
      drive_tick();
      #1;
      tests++;
      if ({bus.tx, bus.tx_busy, bus.tx_done_tick} !== 3'b100) begin
        fails++;
        $display("[TB] FAIL ignore_after cycle %0d: tx/busy/done=%b%b%b want 100", i,
                 bus.tx, bus.tx_busy, bus.tx_done_tick);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic etx, edone;
    tick_period = 1;
    run_frame(8'h5A, -1, 1'b0, 90, -1);
    for (int k = 0; k < n_cyc; k++) begin
      etx = model_bit(8'h5A, rec_ticks[k]);
      tests++;
      if ({rec_tx[k], rec_busy[k], rec_done[k]} !== {etx, 1'b1, 1'b0}) begin
        fails++;
        $display("[TB] FAIL abort_frame cycle %0d: tx/busy/done=%b%b%b want %b10",
                 k, rec_tx[k], rec_busy[k], rec_done[k], etx);
      end
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      reset = 1'b0;
      drive_tick();
      #1;
      tests++;
      if ({bus.tx, bus.tx_busy, bus.tx_done_tick} !== 3'b100) begin
        fails++;
        $display("[TB] FAIL abort_idle cycle %0d: tx/busy/done=%b%b%b want 100", i,
                 bus.tx, bus.tx_busy, bus.tx_done_tick);
      end
    end
    run_frame(8'h0F, -1, 1'b0, -1, -1);
    for (int k = 0; k < n_cyc; k++) begin
      etx = model_bit(8'h0F, rec_ticks[k]);
      edone = rec_stick[k] && (rec_ticks[k] == FRAME_TICKS - 1);
      tests++;
      if ({rec_tx[k], rec_busy[k], rec_done[k]} !== {etx, 1'b1, edone}) begin
        fails++;
        $display("[TB] FAIL abort_next_frame cycle %0d: tx/busy/done=%b%b%b want %b1%b",
                 k, rec_tx[k], rec_busy[k], rec_done[k], etx, edone);
      end
    end
  endtask

  task automatic test_loopback();
    logic [DBIT-1:0] data;
    logic            etx, edone;
    int              ndone;
    int              freeze;
    ndone = 0;
    for (int f = 0; f < 9; f++) begin
      // First three frames at 1-in-4 ticks, then random words, rates and stalls.
      if (f == 0) data = 8'h00;
      else if (f == 1) data = 8'hFF;
      else if (f == 2) data = 8'hA5;
      else data = DBIT'($urandom);
      tick_period = (f < 3) ? 4 : int'($urandom_range(1, 3));
      freeze = (f >= 3 && f % 2 == 1) ? int'($urandom_range(0, 120)) : -1;
      run_frame(data, -1, 1'b0, -1, freeze);
      for (int k = 0; k < n_cyc; k++) begin
        etx = model_bit(data, rec_ticks[k]);
        edone = rec_stick[k] && (rec_ticks[k] == FRAME_TICKS - 1);
        if (f < 3 && rec_done[k] === 1'b1) ndone++;
        tests++;
        if ({rec_tx[k], rec_busy[k], rec_done[k]} !== {etx, 1'b1, edone}) begin
          fails++;
          $display("[TB] FAIL loop_frame %0d cycle %0d: tx/busy/done=%b%b%b want %b1%b",
                   f, k, rec_tx[k], rec_busy[k], rec_done[k], etx, edone);
        end
      end
      tests++;
      if ({rx_bit(0), rx_word(), rx_bit(DBIT + 2)} !== {1'b0, data, 1'b1}) begin
        fails++;
        $display("[TB] FAIL loop_rx_word %0d: start/data/stop=%b/%h/%b want 0/%h/1",
                 f, rx_bit(0), rx_word(), rx_bit(DBIT + 2), data);
      end
      tests++;
      if (rx_parity_err() !== 1'b0) begin
        fails++;
        $display("[TB] FAIL loop_rx_parity %0d: parity error %b want 0", f, rx_parity_err());
      end
    end
    tests++;
    if (ndone !== 3) begin
      fails++;
      $display("[TB] FAIL loop_done_count: got %0d want 3", ndone);
    end
  endtask

  task automatic test_back_to_back();
    logic [DBIT-1:0] data;
    tick_period = 1;
    for (int f = 0; f < 2; f++) begin
      data = DBIT'($urandom);
      run_frame(data, -1, 1'b0, -1, -1);
      tests++;
      if ({pre_tx, pre_busy, rec_tx[0], rec_busy[0]} !== 4'b1001) begin
        fails++;
        $display("[TB] FAIL b2b_gap %0d: idle tx/busy=%b%b first tx/busy=%b%b want 10 01",
                 f, pre_tx, pre_busy, rec_tx[0], rec_busy[0]);
      end
      tests++;
      if (rx_word() !== data) begin
        fails++;
        $display("[TB] FAIL b2b_word %0d: got %h want %h", f, rx_word(), data);
      end
    end
  endtask

  initial begin
    bus.tx_start = 1'b0;
    bus.din = '0;
    test_reset();
    test_parity();
    test_ignore();
    test_reset_midframe();
    test_loopback();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
